// File: rtl/matmul_tile_sequencer_if.sv
// Host bank-access bus for matmul_tile_sequencer.
//   master : host side, drives select/address/data/strobes, receives read data,
//            read-valid and error.
//   slave  : sequencer side.
interface matmul_tile_sequencer_if #(
  parameter int AWIDTH    = 11,
  parameter int DWIDTH    = 64,
  parameter int SEL_WIDTH = 8
);
  logic [SEL_WIDTH-1:0] host_sel;
  logic [AWIDTH-1:0]    host_addr;
  logic [DWIDTH-1:0]    host_wdata;
  logic                 host_we;
  logic                 host_re;
  logic [DWIDTH-1:0]    host_rdata;
  logic                 host_rvalid;
  logic                 host_err;

  modport master (
    output host_sel, host_addr, host_wdata, host_we, host_re,
    input  host_rdata, host_rvalid, host_err
  );

  modport slave (
    input  host_sel, host_addr, host_wdata, host_we, host_re,
    output host_rdata, host_rvalid, host_err
  );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// Tile sequencer for a matmul compute core plus host access to the tile banks.
// Ports:
//   clk, resetn (sync, active-low)
//   start/clear_done/num_tiles/base_addr_*/tile_stride_* : job control
//   core_start/core_done/core_addr_* : per-tile handshake with the compute core
//   busy/done/tile_idx : job status
//   host (slave modport) : host bank read/write bus
//   bank_addr/bank_wdata/bank_we/bank_rdata : flattened per-bank BRAM ports
//
// state     | meaning
// S_IDLE    | waiting for start
// S_LAUNCH  | core_start pulse for current tile
// S_WAIT    | waiting for core_done
// S_ADVANCE | step to next tile or finish
// S_DONE    | job complete, waiting for clear_done
module matmul_tile_sequencer #(
  parameter int NUM_BANKS    = 6,
  parameter int AWIDTH       = 11,
  parameter int DWIDTH       = 64,
  parameter int SEL_WIDTH    = 8,
  parameter int TILE_WIDTH   = 8,
  parameter int STRIDE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        clear_done,
  input  logic [TILE_WIDTH-1:0]       num_tiles,
  input  logic [AWIDTH-1:0]           base_addr_a,
  input  logic [AWIDTH-1:0]           base_addr_b,
  input  logic [AWIDTH-1:0]           base_addr_c,
  input  logic [STRIDE_WIDTH-1:0]     tile_stride_a,
  input  logic [STRIDE_WIDTH-1:0]     tile_stride_b,
  input  logic [STRIDE_WIDTH-1:0]     tile_stride_c,
  output logic                        core_start,
  input  logic                        core_done,
  output logic [AWIDTH-1:0]           core_addr_a,
  output logic [AWIDTH-1:0]           core_addr_b,
  output logic [AWIDTH-1:0]           core_addr_c,
  output logic                        busy,
  output logic                        done,
  output logic [TILE_WIDTH-1:0]       tile_idx,
  matmul_tile_sequencer_if.slave      host,
  output logic [NUM_BANKS*AWIDTH-1:0] bank_addr,
  output logic [NUM_BANKS*DWIDTH-1:0] bank_wdata,
  output logic [NUM_BANKS-1:0]        bank_we,
  input  logic [NUM_BANKS*DWIDTH-1:0] bank_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [TILE_WIDTH-1:0]   tile_idx_q, tile_idx_d;
  logic [TILE_WIDTH-1:0]   ntiles_q, ntiles_d;
  logic [STRIDE_WIDTH-1:0] stride_a_q, stride_a_d;
  logic [STRIDE_WIDTH-1:0] stride_b_q, stride_b_d;
  logic [STRIDE_WIDTH-1:0] stride_c_q, stride_c_d;
  logic [AWIDTH-1:0]       addr_a_q, addr_a_d;
  logic [AWIDTH-1:0]       addr_b_q, addr_b_d;
  logic [AWIDTH-1:0]       addr_c_q, addr_c_d;

  // Addresses are accumulated one stride per tile, so the sum wraps
  // naturally mod 2^AWIDTH and no multiplier is needed.
  always_comb begin
    state_d    = state_q;
    tile_idx_d = tile_idx_q;
    ntiles_d   = ntiles_q;
    stride_a_d = stride_a_q;
    stride_b_d = stride_b_q;
    stride_c_d = stride_c_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    addr_c_d   = addr_c_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ntiles_d   = num_tiles;
          stride_a_d = tile_stride_a;
          stride_b_d = tile_stride_b;
          stride_c_d = tile_stride_c;
          addr_a_d   = base_addr_a;
          addr_b_d   = base_addr_b;
          addr_c_d   = base_addr_c;
          tile_idx_d = '0;
          state_d    = (num_tiles != '0) ? S_LAUNCH : S_DONE;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (tile_idx_q == ntiles_q - TILE_WIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
          tile_idx_d = tile_idx_q + TILE_WIDTH'(1);
          addr_a_d   = addr_a_q + AWIDTH'(stride_a_q);
          addr_b_d   = addr_b_q + AWIDTH'(stride_b_q);
          addr_c_d   = addr_c_q + AWIDTH'(stride_c_q);
          state_d    = S_LAUNCH;
        end
      end
      S_DONE: begin
        if (clear_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      tile_idx_q <= '0;
      ntiles_q   <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      stride_c_q <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_c_q   <= '0;
    end else begin
      state_q    <= state_d;
      tile_idx_q <= tile_idx_d;
      ntiles_q   <= ntiles_d;
      stride_a_q <= stride_a_d;
      stride_b_q <= stride_b_d;
      stride_c_q <= stride_c_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      addr_c_q   <= addr_c_d;
    end
  end

  assign core_start  = (state_q == S_LAUNCH);
  assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_ADVANCE);
  assign done        = (state_q == S_DONE);
  assign tile_idx    = tile_idx_q;
  assign core_addr_a = addr_a_q;
  assign core_addr_b = addr_b_q;
  assign core_addr_c = addr_c_q;

  // Host bank access
  logic sel_valid;
  assign sel_valid = (host.host_sel < SEL_WIDTH'(NUM_BANKS));

  // Write data is broadcast; only the write enable is steered.
  // resetn gates the enables so a held host_we cannot corrupt banks in reset.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign bank_addr[gi*AWIDTH +: AWIDTH]  = host.host_addr;
    assign bank_wdata[gi*DWIDTH +: DWIDTH] = host.host_wdata;
    assign bank_we[gi] = resetn & host.host_we & ~busy & sel_valid &
                         (host.host_sel == SEL_WIDTH'(gi));
  end

  logic                 rd_pend_q;
  logic [SEL_WIDTH-1:0] rd_sel_q;
  logic [DWIDTH-1:0]    rd_word;
  logic [DWIDTH-1:0]    host_rdata_q;
  logic                 host_rvalid_q;
  logic                 host_err_q, host_err_d;

  // An out-of-range registered select matches no bank and returns zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_sel_q == SEL_WIDTH'(i)) rd_word = bank_rdata[i*DWIDTH +: DWIDTH];
    end
  end

  assign host_err_d = (host.host_we & (busy | ~sel_valid)) | (host.host_re & ~sel_valid);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_pend_q     <= 1'b0;
      rd_sel_q      <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_err_q    <= 1'b0;
    end else begin
      rd_pend_q     <= host.host_re;
      rd_sel_q      <= host.host_sel;
      host_rvalid_q <= rd_pend_q;
      if (rd_pend_q) host_rdata_q <= rd_word;
      host_err_q    <= host_err_d;
    end
  end

  assign host.host_rdata  = host_rdata_q;
  assign host.host_rvalid = host_rvalid_q;
  assign host.host_err    = host_err_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
module tb_matmul_tile_sequencer;
  localparam int NB = 6, AW = 11, DW = 64, SW = 8, TW = 8, STW = 8;

  logic clk = 1'b0;
  logic resetn, start, clear_done, core_done;
  logic [TW-1:0]  num_tiles;
  logic [AW-1:0]  base_addr_a, base_addr_b, base_addr_c;
  logic [STW-1:0] tile_stride_a, tile_stride_b, tile_stride_c;
  logic           core_start, busy, done;
  logic [AW-1:0]  core_addr_a, core_addr_b, core_addr_c;
  logic [TW-1:0]  tile_idx;
  logic [NB*AW-1:0] bank_addr;
  logic [NB*DW-1:0] bank_wdata, bank_rdata;
  logic [NB-1:0]    bank_we;

  matmul_tile_sequencer_if #(.AWIDTH(AW), .DWIDTH(DW), .SEL_WIDTH(SW)) hif ();

  matmul_tile_sequencer #(
    .NUM_BANKS(NB), .AWIDTH(AW), .DWIDTH(DW), .SEL_WIDTH(SW),
    .TILE_WIDTH(TW), .STRIDE_WIDTH(STW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .clear_done(clear_done),
    .num_tiles(num_tiles),
    .base_addr_a(base_addr_a), .base_addr_b(base_addr_b), .base_addr_c(base_addr_c),
    .tile_stride_a(tile_stride_a), .tile_stride_b(tile_stride_b), .tile_stride_c(tile_stride_c),
    .core_start(core_start), .core_done(core_done),
    .core_addr_a(core_addr_a), .core_addr_b(core_addr_b), .core_addr_c(core_addr_c),
    .busy(busy), .done(done), .tile_idx(tile_idx),
    .host(hif),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_we(bank_we),
    .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  // BRAM banks: 1-cycle registered read, read-before-write.
  logic [DW-1:0] mem [NB][2048];
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      bank_rdata[i*DW +: DW] <= mem[i][bank_addr[i*AW +: AW]];
      if (bank_we[i]) mem[i][bank_addr[i*AW +: AW]] <= bank_wdata[i*DW +: DW];
    end
  end

  int total = 0;
  int bad = 0;
  logic [63:0] shadow [int];
  int wkeys[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One host transaction issued in the current cycle, followed through err and rvalid.
  task automatic host_op(input bit we, input bit re, input int sel, input int addr,
                         input logic [63:0] data, input bit busy_now);
    bit ok_w, exp_err;
    int key;
    logic [NB-1:0] exp_we;
    logic [63:0] exp_rd;
    key = sel * 2048 + addr;
    hif.host_we = we; hif.host_re = re; hif.host_sel = SW'(sel);
    hif.host_addr = AW'(addr); hif.host_wdata = data;
    #1;
    ok_w    = we && !busy_now && (sel < NB);
    exp_we  = ok_w ? NB'(1 << sel) : '0;
    exp_err = (we && !ok_w) || (re && sel >= NB);
    exp_rd  = (sel < NB && shadow.exists(key)) ? shadow[key] : 64'd0;
    chk("bank_we", bank_we, exp_we);
    chk("bank_addr0", bank_addr[0 +: AW], addr);
    chk("bank_addr5", bank_addr[5*AW +: AW], addr);
    if (ok_w) begin
      chk("bank_wdata", bank_wdata[sel*DW +: DW], data);
      if (!shadow.exists(key)) wkeys.push_back(key);
      shadow[key] = data;
    end
    step();
    hif.host_we = 1'b0; hif.host_re = 1'b0;
    chk("host_err", hif.host_err, exp_err);
    chk("rvalid_t1", hif.host_rvalid, 1'b0);
    step();
    chk("rvalid_t2", hif.host_rvalid, re);
    if (re) chk("rdata", hif.host_rdata, exp_rd);
    step();
    chk("rvalid_t3", hif.host_rvalid, 1'b0);
    chk("err_t2", hif.host_err, 1'b0);
  endtask

  task automatic run_job(input int n, input int ba, input int bb, input int bc,
                         input int sa, input int sb, input int sc, input int dly);
    start = 1'b1; num_tiles = TW'(n);
    base_addr_a = AW'(ba); base_addr_b = AW'(bb); base_addr_c = AW'(bc);
    tile_stride_a = STW'(sa); tile_stride_b = STW'(sb); tile_stride_c = STW'(sc);
    step();
    start = 1'b0;
    // Inputs are latched at start; scramble them for the rest of the job.
    num_tiles = TW'($urandom);
    base_addr_a = AW'($urandom); base_addr_b = AW'($urandom); base_addr_c = AW'($urandom);
    tile_stride_a = STW'($urandom); tile_stride_b = STW'($urandom); tile_stride_c = STW'($urandom);
    for (int k = 0; k < n; k++) begin
      chk("core_start", core_start, 1'b1);
      chk("tile_idx", tile_idx, k);
      chk("busy_launch", busy, 1'b1);
      chk("addr_a", core_addr_a, (ba + k * sa) & 32'h7FF);
      chk("addr_b", core_addr_b, (bb + k * sb) & 32'h7FF);
      chk("addr_c", core_addr_c, (bc + k * sc) & 32'h7FF);
      step();
      for (int d = 0; d < dly; d++) begin
        chk("cs_wait", core_start, 1'b0);
        chk("addr_a_wait", core_addr_a, (ba + k * sa) & 32'h7FF);
        step();
      end
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      chk("busy_adv", busy, 1'b1);
      chk("cs_adv", core_start, 1'b0);
      step();
    end
    chk("done", done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("cs_done", core_start, 1'b0);
    for (int h = 0; h < 3; h++) begin
      step();
      chk("done_hold", done, 1'b1);
      chk("cs_hold", core_start, 1'b0);
    end
    // start together with clear_done must be ignored
    clear_done = 1'b1; start = 1'b1; num_tiles = 8'd1;
    step();
    clear_done = 1'b0; start = 1'b0;
    chk("done_clr", done, 1'b0);
    chk("busy_clr", busy, 1'b0);
    chk("cs_clr", core_start, 1'b0);
    step();
    chk("cs_after_clr", core_start, 1'b0);
    chk("busy_after_clr", busy, 1'b0);
  endtask

  initial begin
    int mode, sel, addr, key, n;
    logic [63:0] d;
    resetn = 1'b0; start = 1'b0; clear_done = 1'b0; core_done = 1'b0;
    num_tiles = '0; base_addr_a = '0; base_addr_b = '0; base_addr_c = '0;
    tile_stride_a = '0; tile_stride_b = '0; tile_stride_c = '0;
    hif.host_we = 1'b1; hif.host_re = 1'b0; hif.host_sel = '0;
    hif.host_addr = '0; hif.host_wdata = 64'hDEAD;
    #1;
    chk("we_in_reset", bank_we, '0);
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cs", core_start, 1'b0);
    chk("rst_idx", tile_idx, '0);
    chk("rst_addr_a", core_addr_a, '0);
    chk("rst_addr_c", core_addr_c, '0);
    chk("rst_rvalid", hif.host_rvalid, 1'b0);
    chk("rst_rdata", hif.host_rdata, '0);
    chk("rst_err", hif.host_err, 1'b0);
    hif.host_we = 1'b0;
    resetn = 1'b1;
    step();

    // Directed host accesses
    host_op(1, 0, 2, 5, 64'hA5, 0);
    host_op(0, 1, 2, 5, 64'h0, 0);
    host_op(1, 0, 6, 5, 64'h77, 0);
    host_op(0, 1, 9, 5, 64'h0, 0);

    // Random host traffic against the shadow memory
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      d = {$urandom, $urandom};
      if ((mode == 1 || mode == 2) && wkeys.size() > 0) begin
        key = wkeys[$urandom_range(0, wkeys.size() - 1)];
        host_op(mode == 2, 1, key / 2048, key % 2048, d, 0);
      end else if (mode == 3) begin
        host_op(0, 1, $urandom_range(6, 255), $urandom_range(0, 2047), d, 0);
      end else begin
        sel = $urandom_range(0, 7);
        addr = $urandom_range(0, 2047);
        host_op(1, 0, sel, addr, d, 0);
      end
    end

    // Directed jobs
    run_job(3, 'h10, 'h100, 'h200, 8, 4, 2, 3);
    run_job(0, 'h10, 'h20, 'h30, 1, 1, 1, 0);
    run_job(2, 'h0, 'h0, 'h7F8, 1, 2, 16, 1);

    // Random jobs
    for (int j = 0; j < 4; j++) begin
      n = $urandom_range(1, 5);
      run_job(n, $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 4));
    end

    // Host access while a job is waiting on the core
    start = 1'b1; num_tiles = 8'd1; base_addr_a = 11'h40; tile_stride_a = 8'd4;
    step();
    start = 1'b0;
    chk("j25_cs", core_start, 1'b1);
    step();
    chk("j25_busy", busy, 1'b1);
    host_op(1, 0, 1, 7, 64'h1234, 1);
    host_op(0, 1, 2, 5, 64'h0, 1);
    chk("j25_still_wait", busy, 1'b1);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    chk("j25_done", done, 1'b1);
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    chk("j25_idle", done, 1'b0);

    // Reset in WAIT of tile 1 with a read in flight
    start = 1'b1; num_tiles = 8'd3; base_addr_a = 11'h33; tile_stride_a = 8'd5;
    step();
    start = 1'b0;
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    chk("r26_cs", core_start, 1'b1);
    chk("r26_idx", tile_idx, 1);
    step();
    hif.host_re = 1'b1; hif.host_sel = 8'd2; hif.host_addr = 11'd5;
    step();
    hif.host_re = 1'b0;
    resetn = 1'b0;
    hif.host_we = 1'b1; hif.host_sel = 8'd0;
    #1;
    chk("r26_we_rst", bank_we, '0);
    step();
    chk("r26_busy", busy, 1'b0);
    chk("r26_done", done, 1'b0);
    chk("r26_cs0", core_start, 1'b0);
    chk("r26_idx0", tile_idx, '0);
    chk("r26_addr_a", core_addr_a, '0);
    chk("r26_addr_b", core_addr_b, '0);
    chk("r26_rvalid", hif.host_rvalid, 1'b0);
    chk("r26_rdata", hif.host_rdata, '0);
    chk("r26_err", hif.host_err, 1'b0);
    hif.host_we = 1'b0;
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("r26_no_cs", core_start, 1'b0);
      chk("r26_no_rvalid", hif.host_rvalid, 1'b0);
      chk("r26_idle", busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
